// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyser capture path.
package la_pkg;

    localparam int unsigned LA_ADDR_WIDTH = 12;
    localparam int unsigned LA_DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        LA_IDLE      = 3'd0,
        LA_PRE       = 3'd1,
        LA_WAIT_TRIG = 3'd2,
        LA_POST      = 3'd3,
        LA_DONE      = 3'd4
    } la_state_t;

endpackage

// File: rtl/la_trig_match.sv
// Combinational masked compare: hit when every unmasked bit of sample equals value.
module la_trig_match #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] sample,
    input  logic [DATA_WIDTH-1:0] mask,
    input  logic [DATA_WIDTH-1:0] value,
    output logic                  hit_c
);

    assign hit_c = ((sample ^ value) & mask) == '0;

endmodule

// File: rtl/la_capture_ctrl.sv
// Circular-buffer capture controller feeding the sample RAM write port;
// reports trigger and oldest-sample addresses when the post window fills.
module la_capture_ctrl
    import la_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = LA_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = LA_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] pre_depth,
    input  logic [DATA_WIDTH-1:0] trig_mask,
    input  logic [DATA_WIDTH-1:0] trig_value,
    input  logic [DATA_WIDTH-1:0] sample_in,
    input  logic                  sample_vld,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  ram_wen,
    output logic                  busy,
    output logic                  triggered,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] trig_addr,
    output logic [ADDR_WIDTH-1:0] start_addr
);

    la_state_t             state, state_nxt;
    logic [ADDR_WIDTH-1:0] wptr, wptr_nxt;
    logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
    logic [ADDR_WIDTH-1:0] pre_lat, pre_nxt;
    logic [ADDR_WIDTH-1:0] waddr_nxt, taddr_nxt, saddr_nxt, post_len;
    logic [DATA_WIDTH-1:0] din_nxt;
    logic                  wen_nxt, busy_nxt, trig_nxt, done_nxt;
    logic                  wr, hit_c, fire;

    la_trig_match #(.DATA_WIDTH(DATA_WIDTH)) u_match (
        .sample (sample_in),
        .mask   (trig_mask),
        .value  (trig_value),
        .hit_c  (hit_c)
    );

    assign fire     = sample_vld && hit_c;
    // Samples still to write after the trigger sample: MEM_DEPTH - 1 - pre_depth.
    assign post_len = {ADDR_WIDTH{1'b1}} - pre_lat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= LA_IDLE;
            wptr       <= '0;
            cnt        <= '0;
            pre_lat    <= '0;
            ram_waddr  <= '0;
            ram_din    <= '0;
            ram_wen    <= 1'b0;
            busy       <= 1'b0;
            triggered  <= 1'b0;
            done       <= 1'b0;
            trig_addr  <= '0;
            start_addr <= '0;
        end else begin
            state      <= state_nxt;
            wptr       <= wptr_nxt;
            cnt        <= cnt_nxt;
            pre_lat    <= pre_nxt;
            ram_waddr  <= waddr_nxt;
            ram_din    <= din_nxt;
            ram_wen    <= wen_nxt;
            busy       <= busy_nxt;
            triggered  <= trig_nxt;
            done       <= done_nxt;
            trig_addr  <= taddr_nxt;
            start_addr <= saddr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wptr_nxt  = wptr;
        cnt_nxt   = cnt;
        pre_nxt   = pre_lat;
        waddr_nxt = ram_waddr;
        din_nxt   = ram_din;
        wen_nxt   = 1'b0;
        trig_nxt  = triggered;
        done_nxt  = done;
        taddr_nxt = trig_addr;
        saddr_nxt = start_addr;
        wr        = 1'b0;

        if (abort) begin
            state_nxt = LA_IDLE;
            trig_nxt  = 1'b0;
            done_nxt  = 1'b0;
        end else begin
            unique case (state)
                LA_IDLE, LA_DONE: begin
                    if (arm) begin
                        wptr_nxt  = '0;
                        pre_nxt   = pre_depth;
                        cnt_nxt   = pre_depth;
                        state_nxt = (pre_depth == '0) ? LA_WAIT_TRIG : LA_PRE;
                        trig_nxt  = 1'b0;
                        done_nxt  = 1'b0;
                    end
                end
                LA_PRE: begin
                    if (sample_vld) begin
                        wr      = 1'b1;
                        cnt_nxt = cnt - ADDR_WIDTH'(1);
                        if (cnt == ADDR_WIDTH'(1)) state_nxt = LA_WAIT_TRIG;
                    end
                end
                LA_WAIT_TRIG: begin
                    wr = sample_vld;
                    if (fire) begin
                        taddr_nxt = wptr;
                        saddr_nxt = wptr - pre_lat;
                        trig_nxt  = 1'b1;
                        cnt_nxt   = post_len;
                        if (post_len == '0) begin
                            state_nxt = LA_DONE;
                            done_nxt  = 1'b1;
                        end else begin
                            state_nxt = LA_POST;
                        end
                    end
                end
                LA_POST: begin
                    if (sample_vld) begin
                        wr      = 1'b1;
                        cnt_nxt = cnt - ADDR_WIDTH'(1);
                        if (cnt == ADDR_WIDTH'(1)) begin
                            state_nxt = LA_DONE;
                            done_nxt  = 1'b1;
                        end
                    end
                end
                default: state_nxt = LA_IDLE;
            endcase

            if (wr) begin
                wen_nxt   = 1'b1;
                waddr_nxt = wptr;
                din_nxt   = sample_in;
                wptr_nxt  = wptr + ADDR_WIDTH'(1);
            end
        end

        busy_nxt = (state_nxt == LA_PRE) || (state_nxt == LA_WAIT_TRIG) ||
                   (state_nxt == LA_POST);
    end

endmodule

// File: tb/tb_la_capture_ctrl.sv
// Directed bench for la_capture_ctrl with a 16-entry buffer and incrementing sample stream.
module tb_la_capture_ctrl;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          arm, abort, sample_vld;
    logic [AW-1:0] pre_depth;
    logic [DW-1:0] trig_mask, trig_value, sample_in;
    logic [AW-1:0] ram_waddr, trig_addr, start_addr;
    logic [DW-1:0] ram_din;
    logic          ram_wen, busy, triggered, done;

    int checks   = 0;
    int failures = 0;

    la_capture_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .arm        (arm),
        .abort      (abort),
        .pre_depth  (pre_depth),
        .trig_mask  (trig_mask),
        .trig_value (trig_value),
        .sample_in  (sample_in),
        .sample_vld (sample_vld),
        .ram_waddr  (ram_waddr),
        .ram_din    (ram_din),
        .ram_wen    (ram_wen),
        .busy       (busy),
        .triggered  (triggered),
        .done       (done),
        .trig_addr  (trig_addr),
        .start_addr (start_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm_cap(input int pre, input int mask, input int val);
        pre_depth  = AW'(pre);
        trig_mask  = DW'(mask);
        trig_value = DW'(val);
        sample_vld = 1'b0;
        arm        = 1'b1;
        tick();
        arm        = 1'b0;
    endtask

    // Streams incrementing samples (valid every 'period' cycles) until done or budget expires.
    task automatic run_cap(input int period, input int max_cyc,
                           output int nwr, output int nwr_trig, output int seq_err,
                           output int gap_wen, output int trig_wa, output int trig_din,
                           output int last_wa, output int done_on_wr, output int done_seen);
        int idx;
        int seen;
        idx = 0; nwr = 0; nwr_trig = 0; seq_err = 0; gap_wen = 0;
        trig_wa = -1; trig_din = -1; last_wa = -1; done_on_wr = 0; done_seen = 0; seen = 0;
        for (int k = 0; k < max_cyc; k++) begin
            sample_vld = ((k % period) == 0);
            sample_in  = DW'(idx);
            tick();
            if (ram_wen) begin
                if (ram_waddr != AW'(nwr) || ram_din != DW'(nwr)) seq_err++;
                if (!sample_vld) gap_wen++;
                nwr++;
                if (triggered) nwr_trig++;
            end
            if (triggered && seen == 0) begin
                seen     = 1;
                trig_wa  = ram_wen ? int'(ram_waddr) : -2;
                trig_din = int'(ram_din);
            end
            if (sample_vld) idx++;
            if (done) begin
                done_seen  = 1;
                done_on_wr = int'(ram_wen);
                last_wa    = int'(ram_waddr);
                break;
            end
        end
        sample_vld = 1'b0;
    endtask

    int nwr, nwr_trig, seq_err, gap_wen, trig_wa, trig_din, last_wa, done_on_wr, done_seen;
    int extra;

    initial begin
        rst_n = 1'b0; arm = 1'b0; abort = 1'b0; sample_vld = 1'b0;
        pre_depth = '0; trig_mask = '0; trig_value = '0; sample_in = '0;
        tick(); tick();
        check("rst_outputs", int'({ram_wen, busy, triggered, done}), 0);
        check("rst_addrs", int'({ram_waddr, ram_din, trig_addr, start_addr}), 0);
        rst_n = 1'b1;
        tick();

        // Basic capture
        arm_cap(4, 8'hFF, 8'hA5);
        check("t1_busy_after_arm", int'(busy), 1);
        check("t1_trig_after_arm", int'(triggered), 0);
        run_cap(1, 400, nwr, nwr_trig, seq_err, gap_wen, trig_wa, trig_din, last_wa, done_on_wr, done_seen);
        check("t1_done_seen", done_seen, 1);
        check("t1_trig_write_addr", trig_wa, 5);
        check("t1_trig_write_data", trig_din, 8'hA5);
        check("t1_trig_addr", int'(trig_addr), 5);
        check("t1_start_addr", int'(start_addr), 1);
        check("t1_writes_total", nwr, 177);
        check("t1_writes_from_trig", nwr_trig, 12);
        check("t1_last_addr", last_wa, 0);
        check("t1_done_on_write", done_on_wr, 1);
        check("t1_seq", seq_err, 0);
        check("t1_busy_at_done", int'(busy), 0);

        // Trigger match during PRE ignored
        arm_cap(4, 8'hFF, 8'h02);
        check("t2_done_cleared", int'(done), 0);
        check("t2_trig_cleared", int'(triggered), 0);
        run_cap(1, 400, nwr, nwr_trig, seq_err, gap_wen, trig_wa, trig_din, last_wa, done_on_wr, done_seen);
        check("t2_done_seen", done_seen, 1);
        check("t2_trig_addr", int'(trig_addr), 2);
        check("t2_start_addr", int'(start_addr), 14);
        check("t2_writes_total", nwr, 270);
        check("t2_writes_from_trig", nwr_trig, 12);
        check("t2_seq", seq_err, 0);

        // No pre-trigger
        arm_cap(0, 8'hFF, 8'h00);
        run_cap(1, 100, nwr, nwr_trig, seq_err, gap_wen, trig_wa, trig_din, last_wa, done_on_wr, done_seen);
        check("t3_done_seen", done_seen, 1);
        check("t3_trig_addr", int'(trig_addr), 0);
        check("t3_start_addr", int'(start_addr), 0);
        check("t3_writes_total", nwr, 16);
        check("t3_last_addr", last_wa, 15);
        check("t3_done_on_write", done_on_wr, 1);
        check("t3_seq", seq_err, 0);

        // Maximum pre-trigger: done on the trigger write itself
        arm_cap(15, 8'hFF, 8'h20);
        run_cap(1, 100, nwr, nwr_trig, seq_err, gap_wen, trig_wa, trig_din, last_wa, done_on_wr, done_seen);
        check("t4_done_seen", done_seen, 1);
        check("t4_trig_write_addr", trig_wa, 0);
        check("t4_trig_addr", int'(trig_addr), 0);
        check("t4_start_addr", int'(start_addr), 1);
        check("t4_writes_total", nwr, 33);
        check("t4_writes_from_trig", nwr_trig, 1);
        check("t4_done_on_write", done_on_wr, 1);
        extra = 0;
        sample_vld = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (ram_wen) extra++;
        end
        sample_vld = 1'b0;
        check("t4_no_write_in_done", extra, 0);
        check("t4_done_held", int'(done), 1);

        // Gapped stream with nibble mask
        arm_cap(2, 8'hF0, 8'h30);
        run_cap(3, 400, nwr, nwr_trig, seq_err, gap_wen, trig_wa, trig_din, last_wa, done_on_wr, done_seen);
        check("t5_done_seen", done_seen, 1);
        check("t5_trig_write_data", trig_din, 8'h30);
        check("t5_trig_addr", int'(trig_addr), 0);
        check("t5_start_addr", int'(start_addr), 14);
        check("t5_gap_wen", gap_wen, 0);
        check("t5_writes_from_trig", nwr_trig, 14);
        check("t5_writes_total", nwr, 62);
        check("t5_seq", seq_err, 0);

        // Abort in POST
        arm_cap(4, 8'h00, 8'h00);
        sample_vld = 1'b1;
        for (int k = 0; k < 7; k++) begin
            sample_in = DW'(k);
            tick();
        end
        check("t6_trig_before_abort", int'(triggered), 1);
        check("t6_trig_addr", int'(trig_addr), 4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t6_abort_flags", int'({busy, triggered, done}), 0);
        check("t6_abort_no_wen", int'(ram_wen), 0);
        check("t6_abort_trig_addr_held", int'(trig_addr), 4);
        check("t6_abort_start_addr_held", int'(start_addr), 0);
        extra = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (ram_wen) extra++;
        end
        check("t6_no_wen_after_abort", extra, 0);

        // arm and abort together: abort wins
        arm = 1'b1; abort = 1'b1;
        tick();
        arm = 1'b0; abort = 1'b0;
        check("t7_busy_arm_abort", int'(busy), 0);
        tick();
        check("t7_no_wen_arm_abort", int'(ram_wen), 0);
        sample_vld = 1'b0;

        // Reset mid-POST
        arm_cap(4, 8'h00, 8'h00);
        sample_vld = 1'b1;
        for (int k = 0; k < 7; k++) begin
            sample_in = DW'(k);
            tick();
        end
        check("t8_busy_pre_reset", int'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t8_rst_flags", int'({ram_wen, busy, triggered, done}), 0);
        check("t8_rst_addrs", int'({ram_waddr, ram_din, trig_addr, start_addr}), 0);
        #3;
        rst_n = 1'b1;
        extra = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (ram_wen) extra++;
        end
        check("t8_no_wen_after_reset", extra, 0);
        sample_vld = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/la_capture_ctrl.md
# la_capture_ctrl

Capture controller for the logic analyser, directly upstream of the dual-port sample RAM. It accepts a qualified sample stream and writes it into the RAM's write port as a circular buffer. Writes continue until a masked-match trigger occurs and the programmed post-trigger window is filled. On completion it reports the trigger address and the oldest-sample address, so the readout side knows where to start reading.

## Interface
- `ADDR_WIDTH`, default 12: RAM address width; `MEM_DEPTH = 2**ADDR_WIDTH` samples.
- `DATA_WIDTH`, default 8: sample width, equal to RAM data width.
- `clk` input 1: single clock; the same clock drives the RAM write port.
- `rst_n` input 1: reset is asynchronous and active-low.
- `arm` input 1: single-cycle pulse; starts a capture.
- `abort` input 1: single-cycle pulse; cancels the capture and returns to idle.
- `pre_depth` input ADDR_WIDTH: number of samples retained before the trigger; sampled when `arm` is accepted.
- `trig_mask` input DATA_WIDTH: bit mask for the trigger compare.
- `trig_value` input DATA_WIDTH: trigger compare value.
- `sample_in` input DATA_WIDTH: sample data.
- `sample_vld` input 1: `sample_in` is valid this cycle.
- `ram_waddr` output ADDR_WIDTH: RAM write address.
- `ram_din` output DATA_WIDTH: RAM write data.
- `ram_wen` output 1: RAM write enable.
- `busy` output 1: a capture is in progress (states PRE, WAIT_TRIG, POST).
- `triggered` output 1: trigger has been seen in the current capture.
- `done` output 1: capture complete; held until the next `arm` or `abort`.
- `trig_addr` output ADDR_WIDTH: RAM address holding the trigger sample.
- `start_addr` output ADDR_WIDTH: RAM address of the oldest captured sample.

## Operation
- **States:** IDLE, PRE, WAIT_TRIG, POST, DONE.
- **IDLE / DONE, `arm` accepted:**
  - `wptr` clears to 0.
  - `pre_depth` is latched.
  - The counter is loaded with the latched `pre_depth`.
  - Next state is PRE, or WAIT_TRIG if `pre_depth` = 0.
  - `triggered` and `done` clear.
- **Every state except IDLE and DONE:** each `sample_vld` writes `sample_in` at `wptr`, then `wptr` increments modulo `MEM_DEPTH`.
- **PRE:**
  - Trigger compare is ignored.
  - The counter decrements per valid sample; when it reaches 0, next state is WAIT_TRIG.
- **WAIT_TRIG:**
  - Trigger condition: `sample_vld && ((sample_in ^ trig_value) & trig_mask) == 0`.
  - On trigger:
    - that sample is written;
    - `trig_addr` = `wptr`;
    - `start_addr` = `wptr - pre_depth` (mod `MEM_DEPTH`);
    - `triggered` = 1;
    - the counter is loaded with `MEM_DEPTH - 1 - pre_depth`;
    - next state is POST, or DONE if that count is 0.
- **POST:** the counter decrements per valid sample; the write that takes it to 0 moves the FSM to DONE.
- **DONE:** no writes; `done` = 1; outputs hold.
- **`abort`:**
  - In any state: next state is IDLE, with no write that cycle.
  - `busy`, `triggered` and `done` clear.
  - `trig_addr` and `start_addr` hold.
- **Priority:** `abort` beats `arm`. `arm` is ignored while `busy`.
- **Capture size:** total samples written after the trigger, including the trigger sample, is `MEM_DEPTH - pre_depth`. Once the buffer has wrapped, a full capture holds exactly `MEM_DEPTH` samples.
- **Arithmetic:** all address arithmetic is ADDR_WIDTH-bit unsigned and wraps.

## Timing
- All outputs are registered.
- **Write latency:** `ram_wen`, `ram_waddr` and `ram_din` are valid the cycle after the `sample_vld` cycle. `ram_wen` is high for exactly one cycle per written sample.
- **Trigger flags:** `triggered`, `trig_addr` and `start_addr` update on the same edge that presents the trigger write.
- **Completion:** `done` rises on the same edge that presents the final write, and `busy` falls on that edge.
- **Reset values:** all outputs 0; FSM in IDLE; `wptr` and counter 0.
- **Reset mid-operation:** reset takes effect immediately; no write is issued after reset deassertion until a new `arm`.
- **Stalled stream:** gaps in `sample_vld` stall all counters; nothing times out.

## Structure
- **Shared package `la_pkg`:**
  - FSM state encoding (`LA_IDLE`, `LA_PRE`, `LA_WAIT_TRIG`, `LA_POST`, `LA_DONE`);
  - default `ADDR_WIDTH` and `DATA_WIDTH`.
- **Sub-module `la_trig_match`:** combinational masked compare, reused later by multi-stage triggers.
- **Everything else** (FSM, write pointer, counter, output registers) stays in this module.

## Test plan
All scenarios use `ADDR_WIDTH`=4 (`MEM_DEPTH` 16) and `DATA_WIDTH`=8. The stimulus is an incrementing sample stream 0x00, 0x01, … with `sample_vld` continuous unless stated.
- **Basic capture:** `pre_depth`=4, mask 0xFF, value 0xA5.
  - Trigger on the 166th sample, written at addr 5 -> `trig_addr`=5, `start_addr`=1.
  - 11 further writes follow; the last is at addr 0, with `done` rising on that edge.
- **Trigger during PRE ignored:** `pre_depth`=4, value 0x02.
  - The match at sample index 2 is ignored.
  - Trigger fires on the next 0x02, which arrives after wrap at index 258 (addr 2) -> `trig_addr`=2, `start_addr`=14.
- **No pre-trigger:** `pre_depth`=0, value 0x00 -> trigger on the first sample.
  - `trig_addr`=0, `start_addr`=0; writes cover addr 0..15; `done` on the 16th write.
- **Maximum pre-trigger:** `pre_depth`=15, value 0x20.
  - `done` and `triggered` rise on the trigger write itself (addr 0) -> `start_addr`=1; no further writes.
- **Gaps and mask:** `sample_vld` toggling 1,0,0,1…, mask 0xF0, value 0x30, `pre_depth`=2.
  - Trigger on 0x30 (earliest qualifying sample).
  - No `ram_wen` in gap cycles.
  - Exactly 14 writes after the trigger write.
- **Abort and reset:**
  - `abort` in POST -> IDLE next cycle; `busy`/`done`/`triggered` = 0; no further `ram_wen`.
  - `arm` and `abort` in the same cycle -> stays IDLE.
  - `rst_n` low mid-POST -> all outputs 0 immediately.
